// File: rtl/partition_table_ctrl.sv
// ---------------------------------------------------------------------------
// partition_table_ctrl
//
// Sequential controller for the partition module table used by PNEW and HALT.
// A PNEW request carries a region bitmask. If region dedup is built in, the
// table is scanned one entry per cycle for an identical mask. A hit reuses
// that module. A miss allocates a fresh module ID in the next free entry.
// Every non-empty PNEW charges popcount(mask) to mu_discovery. FINALIZE
// charges the MDL execution cost of the current module to mu_execution.
// After that the block parks in DONE until reset.
//
// Build option:
//   PTABLE_DEDUP_EN  defined   -> SEARCH state present, duplicate masks reuse
//                                 their existing entry.
//                    undefined -> every PNEW is treated as a miss,
//                                 rsp_reused stays 0.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready request handshake (ready only while idle)
//   req_op          00 PNEW, 01 FINALIZE, 10/11 reserved (rejected)
//   req_mask        PNEW region bitmask
//   rsp_valid       one-cycle completion pulse
//   rsp_module_id   ID of created/reused module (held until next response)
//   rsp_reused      PNEW matched an existing entry (held)
//   rsp_error       request rejected or table full (held)
//   num_modules     number of valid table entries
//   cur_valid       a current module is defined
//   cur_idx         table index of the current module
//   mu_discovery    accumulated discovery cost
//   mu_execution    accumulated execution cost
//   mu_total        mu_discovery + mu_execution, always coherent with them
//   done            FINALIZE completed, sticky until reset
// ---------------------------------------------------------------------------
module partition_table_ctrl #(
    parameter int MAX_MODULES = 64,
    parameter int MASK_W      = 64,
    parameter int ID_W        = 32,
    parameter int MU_W        = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [1:0]                         req_op,
    input  logic [MASK_W-1:0]                  req_mask,
    output logic                               rsp_valid,
    output logic [ID_W-1:0]                    rsp_module_id,
    output logic                               rsp_reused,
    output logic                               rsp_error,
    output logic [$clog2(MAX_MODULES+1)-1:0]   num_modules,
    output logic                               cur_valid,
    output logic [$clog2(MAX_MODULES)-1:0]     cur_idx,
    output logic [MU_W-1:0]                    mu_discovery,
    output logic [MU_W-1:0]                    mu_execution,
    output logic [MU_W-1:0]                    mu_total,
    output logic                               done
);

    localparam int CNT_W = $clog2(MAX_MODULES + 1);
    localparam int IDX_W = $clog2(MAX_MODULES);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MODULES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_COMMIT = 3'd2,
        ST_FINAL  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q,      state_d;
    logic [MASK_W-1:0]  mask_q,       mask_d;       // latched request mask
    logic [IDX_W-1:0]   idx_q,        idx_d;        // search pointer / hit index
    logic               hit_q,        hit_d;        // search found a match
    logic [CNT_W-1:0]   num_q,        num_d;
    logic [ID_W-1:0]    next_id_q,    next_id_d;
    logic               cur_valid_q,  cur_valid_d;
    logic [IDX_W-1:0]   cur_idx_q,    cur_idx_d;
    logic [MU_W-1:0]    mu_disc_q,    mu_disc_d;
    logic [MU_W-1:0]    mu_exec_q,    mu_exec_d;
    logic [MU_W-1:0]    mu_total_q,   mu_total_d;
    logic               rsp_valid_q,  rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q,     rsp_id_d;
    logic               rsp_reused_q, rsp_reused_d;
    logic               rsp_error_q,  rsp_error_d;
    logic               ready_q,      ready_d;
    logic               done_q,       done_d;

    // Table storage. Entries at or above num_q are stale and never read as
    // valid, so reset only needs to clear the count, not the arrays.
    logic [MASK_W-1:0]  mask_mem [MAX_MODULES];
    logic [ID_W-1:0]    id_mem   [MAX_MODULES];

    logic               wr_en;
    logic [IDX_W-1:0]   wr_addr;
    logic [MASK_W-1:0]  cur_mask;

    assign wr_addr  = num_q[IDX_W-1:0];
    assign cur_mask = mask_mem[cur_idx_q];

`ifdef PTABLE_DEDUP_EN
    logic search_match;
    logic search_last;

    assign search_match = (mask_mem[idx_q] == mask_q);
    assign search_last  = (CNT_W'(idx_q) == (num_q - CNT_W'(1)));
`endif

    // ------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------
    function automatic logic [MU_W-1:0] popcnt(input logic [MASK_W-1:0] m);
        logic [MU_W-1:0] r;
        r = '0;
        for (int i = 0; i < MASK_W; i++) begin
            r = r + MU_W'(m[i]);
        end
        return r;
    endfunction

    // bit_length(h) * popcount(m), where h is the index of the highest set
    // bit of m and bit_length(0) is defined as 1.
    function automatic logic [MU_W-1:0] exec_cost(input logic [MASK_W-1:0] m);
        int h;
        int pc;
        int bl;
        h  = 0;
        pc = 0;
        bl = 1;
        for (int i = 0; i < MASK_W; i++) begin
            if (m[i]) begin
                h  = i;
                pc = pc + 1;
            end
        end
        for (int i = 0; i < 31; i++) begin
            if (h[i]) begin
                bl = i + 1;
            end
        end
        return MU_W'(bl * pc);
    endfunction

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        idx_d        = idx_q;
        hit_d        = hit_q;
        num_d        = num_q;
        next_id_d    = next_id_q;
        cur_valid_d  = cur_valid_q;
        cur_idx_d    = cur_idx_q;
        mu_disc_d    = mu_disc_q;
        mu_exec_d    = mu_exec_q;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_reused_d = rsp_reused_q;
        rsp_error_d  = rsp_error_q;
        done_d       = done_q;
        wr_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    case (req_op)
                        2'b00: begin
                            mask_d = req_mask;
                            idx_d  = '0;
                            hit_d  = 1'b0;
`ifdef PTABLE_DEDUP_EN
                            // A zero mask is rejected in COMMIT, so skip the scan.
                            if ((req_mask != '0) && (num_q != '0)) begin
                                state_d = ST_SEARCH;
                            end else begin
                                state_d = ST_COMMIT;
                            end
`else
                            state_d = ST_COMMIT;
`endif
                        end
                        2'b01: begin
                            state_d = ST_FINAL;
                        end
                        default: begin
                            // Reserved op: answered straight from IDLE.
                            rsp_valid_d  = 1'b1;
                            rsp_error_d  = 1'b1;
                            rsp_reused_d = 1'b0;
                            rsp_id_d     = '0;
                        end
                    endcase
                end
            end

`ifdef PTABLE_DEDUP_EN
            ST_SEARCH: begin
                if (search_match) begin
                    hit_d   = 1'b1;
                    state_d = ST_COMMIT;
                end else if (search_last) begin
                    state_d = ST_COMMIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
`endif

            ST_COMMIT: begin
                state_d      = ST_IDLE;
                rsp_valid_d  = 1'b1;
                rsp_reused_d = 1'b0;
                rsp_error_d  = 1'b0;
                if (mask_q == '0) begin
                    rsp_error_d = 1'b1;
                    rsp_id_d    = '0;
                end else begin
                    mu_disc_d = mu_disc_q + popcnt(mask_q);
                    // hit_q can only be set by SEARCH, so without dedup this
                    // branch is dead and rsp_reused stays 0.
                    if (hit_q) begin
                        cur_valid_d  = 1'b1;
                        cur_idx_d    = idx_q;
                        rsp_reused_d = 1'b1;
                        rsp_id_d     = id_mem[idx_q];
                    end else if (num_q < MAX_CNT) begin
                        wr_en       = 1'b1;
                        cur_valid_d = 1'b1;
                        cur_idx_d   = wr_addr;
                        rsp_id_d    = next_id_q;
                        next_id_d   = next_id_q + ID_W'(1);
                        num_d       = num_q + CNT_W'(1);
                    end else begin
                        rsp_error_d = 1'b1;
                        rsp_id_d    = '0;
                    end
                end
            end

            ST_FINAL: begin
                state_d      = ST_DONE;
                done_d       = 1'b1;
                rsp_valid_d  = 1'b1;
                rsp_error_d  = 1'b0;
                rsp_reused_d = 1'b0;
                if (cur_valid_q) begin
                    mu_exec_d = mu_exec_q + exec_cost(cur_mask);
                    rsp_id_d  = id_mem[cur_idx_q];
                end else begin
                    rsp_id_d  = '0;
                end
            end

            ST_DONE: begin
                state_d = ST_DONE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered from the same next values, so all three totals move
        // together on one edge.
        mu_total_d = mu_disc_d + mu_exec_d;
        ready_d    = (state_d == ST_IDLE);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mask_q       <= '0;
            idx_q        <= '0;
            hit_q        <= 1'b0;
            num_q        <= '0;
            next_id_q    <= '0;
            cur_valid_q  <= 1'b0;
            cur_idx_q    <= '0;
            mu_disc_q    <= '0;
            mu_exec_q    <= '0;
            mu_total_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_reused_q <= 1'b0;
            rsp_error_q  <= 1'b0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            idx_q        <= idx_d;
            hit_q        <= hit_d;
            num_q        <= num_d;
            next_id_q    <= next_id_d;
            cur_valid_q  <= cur_valid_d;
            cur_idx_q    <= cur_idx_d;
            mu_disc_q    <= mu_disc_d;
            mu_exec_q    <= mu_exec_d;
            mu_total_q   <= mu_total_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_reused_q <= rsp_reused_d;
            rsp_error_q  <= rsp_error_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
        end
    end

    // Table write port (no reset: validity is tracked by num_q).
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mask_mem[wr_addr] <= mask_q;
            id_mem[wr_addr]   <= next_id_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready     = ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_module_id = rsp_id_q;
    assign rsp_reused    = rsp_reused_q;
    assign rsp_error     = rsp_error_q;
    assign num_modules   = num_q;
    assign cur_valid     = cur_valid_q;
    assign cur_idx       = cur_idx_q;
    assign mu_discovery  = mu_disc_q;
    assign mu_execution  = mu_exec_q;
    assign mu_total      = mu_total_q;
    assign done          = done_q;

endmodule

// File: tb/tb_partition_table_ctrl.sv
module tb_partition_table_ctrl;

    localparam int MAXM = 4;

`ifdef PTABLE_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [63:0] req_mask;
    logic        rsp_valid;
    logic [31:0] rsp_module_id;
    logic        rsp_reused;
    logic        rsp_error;
    logic [2:0]  num_modules;
    logic        cur_valid;
    logic [1:0]  cur_idx;
    logic [63:0] mu_discovery;
    logic [63:0] mu_execution;
    logic [63:0] mu_total;
    logic        done;

    partition_table_ctrl #(
        .MAX_MODULES (MAXM),
        .MASK_W      (64),
        .ID_W        (32),
        .MU_W        (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_mask      (req_mask),
        .rsp_valid     (rsp_valid),
        .rsp_module_id (rsp_module_id),
        .rsp_reused    (rsp_reused),
        .rsp_error     (rsp_error),
        .num_modules   (num_modules),
        .cur_valid     (cur_valid),
        .cur_idx       (cur_idx),
        .mu_discovery  (mu_discovery),
        .mu_execution  (mu_execution),
        .mu_total      (mu_total),
        .done          (done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [63:0] m_masks[$];
    int          m_ids[$];
    int          m_next_id;
    bit          m_cur_valid;
    int          m_cur;
    logic [63:0] m_disc;
    logic [63:0] m_exec;
    bit          m_done;

    int tests = 0;
    int fails = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_masks.delete();
        m_ids.delete();
        m_next_id   = 0;
        m_cur_valid = 1'b0;
        m_cur       = 0;
        m_disc      = '0;
        m_exec      = '0;
        m_done      = 1'b0;
    endtask

    // Execution cost from the rule: bit_length(highest set bit) * popcount.
    function automatic logic [63:0] ref_cost(input logic [63:0] m);
        int h;
        int bl;
        h = 0;
        for (int i = 0; i < 64; i++) if (m[i]) h = i;
        bl = (h == 0) ? 1 : $clog2(h + 1);
        return 64'(bl * $countones(m));
    endfunction

    task automatic check_state(input string tag);
        check_eq({tag, ".num"},   64'(num_modules),  64'(m_masks.size()));
        check_eq({tag, ".curv"},  64'(cur_valid),    64'(m_cur_valid));
        if (m_cur_valid) check_eq({tag, ".cur"}, 64'(cur_idx), 64'(m_cur));
        check_eq({tag, ".disc"},  mu_discovery,      m_disc);
        check_eq({tag, ".exec"},  mu_execution,      m_exec);
        check_eq({tag, ".total"}, mu_total,          m_disc + m_exec);
        check_eq({tag, ".done"},  64'(done),         64'(m_done));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".ready"},  64'(req_ready),     64'd0);
        check_eq({tag, ".rspv"},   64'(rsp_valid),     64'd0);
        check_eq({tag, ".id"},     64'(rsp_module_id), 64'd0);
        check_eq({tag, ".reused"}, 64'(rsp_reused),    64'd0);
        check_eq({tag, ".err"},    64'(rsp_error),     64'd0);
        check_eq({tag, ".num"},    64'(num_modules),   64'd0);
        check_eq({tag, ".curv"},   64'(cur_valid),     64'd0);
        check_eq({tag, ".cur"},    64'(cur_idx),       64'd0);
        check_eq({tag, ".disc"},   mu_discovery,       64'd0);
        check_eq({tag, ".exec"},   mu_execution,       64'd0);
        check_eq({tag, ".total"},  mu_total,           64'd0);
        check_eq({tag, ".done"},   64'(done),          64'd0);
    endtask

    // Called on a negedge. Holds rst for one rising edge, checks the
    // cleared outputs, then releases and checks ready comes up next cycle.
    task automatic do_reset(input string tag);
        rst       = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check_all_zero(tag);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_eq({tag, ".ready_up"}, 64'(req_ready), 64'd1);
        $display("[TB] RESET %s", tag);
    endtask

    // Called on a negedge. Returns on the negedge where rsp_valid is seen;
    // lat = rising edges from the handshake edge to that point.
    task automatic issue(input logic [1:0] op, input logic [63:0] mask, output int lat);
        int w;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) check_eq("ready_timeout", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_mask  = mask;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 2'($urandom_range(3));
        req_mask  = {$urandom(), $urandom()};
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
            req_mask = {$urandom(), $urandom()};
        end
        if (lat >= 200) check_eq("rsp_timeout", 64'(rsp_valid), 64'd1);
    endtask

    task automatic pnew(input logic [63:0] mask);
        int          n;
        int          hit;
        int          s;
        int          lat;
        bit          e_err;
        bit          e_reused;
        logic [63:0] e_id;
        n        = m_masks.size();
        hit      = -1;
        s        = 0;
        e_err    = 1'b0;
        e_reused = 1'b0;
        e_id     = '0;
        if (mask == '0) begin
            e_err = 1'b1;
        end else begin
            if (DEDUP) begin
                for (int j = 0; j < n; j++) begin
                    if (hit < 0 && m_masks[j] == mask) hit = j;
                end
                s = (hit >= 0) ? hit + 1 : n;
            end
            m_disc = m_disc + 64'($countones(mask));
            if (hit >= 0) begin
                e_reused    = 1'b1;
                e_id        = 64'(m_ids[hit]);
                m_cur       = hit;
                m_cur_valid = 1'b1;
            end else if (n < MAXM) begin
                m_masks.push_back(mask);
                m_ids.push_back(m_next_id);
                e_id        = 64'(m_next_id);
                m_next_id++;
                m_cur       = n;
                m_cur_valid = 1'b1;
            end else begin
                e_err = 1'b1;
            end
        end
        issue(2'b00, mask, lat);
        $display("[TB] PNEW mask=0x%016h id=%0d reused=%0d err=%0d lat=%0d",
                 mask, rsp_module_id, rsp_reused, rsp_error, lat);
        check_eq("pnew.lat",    64'(lat),           64'(1 + s));
        check_eq("pnew.id",     64'(rsp_module_id), e_id);
        check_eq("pnew.reused", 64'(rsp_reused),    64'(e_reused));
        check_eq("pnew.err",    64'(rsp_error),     64'(e_err));
        check_eq("pnew.ready",  64'(req_ready),     64'd1);
        check_state("pnew");
    endtask

    task automatic finalize();
        int lat;
        int seen;
        if (m_cur_valid) m_exec = m_exec + ref_cost(m_masks[m_cur]);
        m_done = 1'b1;
        issue(2'b01, '0, lat);
        $display("[TB] FINALIZE exec=%0d total=%0d lat=%0d", mu_execution, mu_total, lat);
        check_eq("fin.lat",   64'(lat),       64'd1);
        check_eq("fin.err",   64'(rsp_error), 64'd0);
        check_eq("fin.ready", 64'(req_ready), 64'd0);
        check_state("fin");
        // A request offered in DONE must never be taken.
        seen = 0;
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_mask  = 64'h1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        req_valid = 1'b0;
        check_eq("done.no_accept", 64'(seen), 64'd0);
        check_state("done.hold");
    endtask

    task automatic reserved(input logic [1:0] op);
        int lat;
        issue(op, {$urandom(), $urandom()}, lat);
        $display("[TB] RESERVED op=%0d err=%0d lat=%0d", op, rsp_error, lat);
        check_eq("rsv.lat",   64'(lat),           64'd0);
        check_eq("rsv.err",   64'(rsp_error),     64'd1);
        check_eq("rsv.id",    64'(rsp_module_id), 64'd0);
        check_eq("rsv.ready", 64'(req_ready),     64'd1);
        check_state("rsv");
    endtask

    logic [63:0] pool [6];

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_mask  = '0;
        pool[0] = 64'h1;
        pool[1] = 64'h2;
        pool[2] = 64'h30;
        pool[3] = 64'h8000_0000_0000_0000;
        pool[4] = 64'hFF00;
        pool[5] = 64'hA5;
        model_reset();
        @(negedge clk);
        do_reset("init");

        // First PNEW on an empty table, then dedup of a repeated mask.
        pnew(64'h1);
        pnew(64'h2);
        pnew(64'h1);

        // Execution cost of 0x30: bit_length(5)=3, popcount=2.
        do_reset("r1");
        pnew(64'h30);
        finalize();

        // FINALIZE with no current module.
        do_reset("r2");
        finalize();

        // Table overflow, zero mask and reserved ops.
        do_reset("r3");
        pnew(64'h1);
        pnew(64'h2);
        pnew(64'h4);
        pnew(64'h8);
        pnew(64'h10);
        pnew(64'h0);
        reserved(2'b10);
        reserved(2'b11);

        // Reset while a PNEW is in flight (SEARCH when dedup is built in).
        do_reset("r4");
        pnew(64'h1);
        pnew(64'h2);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_mask  = 64'h40;
        @(negedge clk);
        req_valid = 1'b0;
        do_reset("midsearch");
        pnew(64'h4);

        // Randomized traffic.
        for (int it = 0; it < 300; it++) begin
            int r;
            int p;
            if (m_done) do_reset("after_done");
            r = $urandom_range(99);
            if (r < 4) begin
                do_reset("rand");
            end else if (r < 9) begin
                finalize();
            end else if (r < 12) begin
                reserved(2'($urandom_range(3, 2)));
            end else begin
                p = $urandom_range(7);
                if (p < 6)       pnew(pool[p]);
                else if (p == 6) pnew(64'h0);
                else             pnew({$urandom(), $urandom()});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/partition_table_ctrl.md
# partition_table_ctrl

Sequential controller for the partition module table that the μ-core drives on PNEW and HALT. It accepts module-creation requests and searches the table one entry per cycle to deduplicate regions, then allocates module IDs and tracks the current module. It charges μ-discovery, and on finalize it charges the MDL execution cost and publishes μ-total. It sits between the instruction decoder and the μ-accounting/state-hash logic and replaces the ad-hoc table handling in the simulation harnesses.

## Interface
- MAX_MODULES, 64, table depth (entries)
- MASK_W, 64, region bitmask width
- ID_W, 32, module ID width
- MU_W, 64, μ accumulator width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (IDLE only)
- req_op  in  2  00 PNEW, 01 FINALIZE, 10/11 reserved
- req_mask  in  MASK_W  PNEW region bitmask
- rsp_valid  out  1  one-cycle completion pulse
- rsp_module_id  out  ID_W  ID of created or reused module
- rsp_reused  out  1  PNEW matched an existing entry
- rsp_error  out  1  request rejected or table full
- num_modules  out  $clog2(MAX_MODULES+1)  valid entries
- cur_valid  out  1  current module defined
- cur_idx  out  $clog2(MAX_MODULES)  current module entry index
- mu_discovery, mu_execution, mu_total  out  MU_W  μ accumulators
- done  out  1  FINALIZE completed; sticky until rst

## Operation
- Reset: all outputs 0, table cleared, next_id=0, cur_valid=0, FSM=IDLE. req_ready=1 from the first cycle after reset deassertion.
- FSM states: IDLE, SEARCH, COMMIT, FINAL, DONE. A handshake occurs on req_valid&&req_ready. The request is latched and req_* are ignored until the next IDLE.
- PNEW in IDLE: if num_modules>0, go to SEARCH at idx 0; otherwise go to COMMIT.
- SEARCH: compare entry[idx].mask with the latched mask each cycle.
  - On match, go to COMMIT (hit, idx kept).
  - On idx==num_modules-1 with no match, go to COMMIT (miss).
  - Otherwise idx+1.
- COMMIT actions:
  - mu_discovery += popcount(mask) always, including hit and full cases.
  - Hit: cur_idx=idx, rsp_reused=1, rsp_module_id=entry ID.
  - Miss with space: write {next_id, mask} at entry num_modules, cur_idx=that entry, next_id+1, num_modules+1.
  - Miss when full: no write, cur_* unchanged, rsp_error=1, rsp_module_id=0.
  - Every path ends in IDLE.
- PNEW with mask==0: no search and no charge. COMMIT asserts rsp_error only.
- FINALIZE: go to FINAL.
  - If cur_valid: cost = bit_length(h)*popcount(m), where m=entry[cur_idx].mask and h=highest set bit of m; bit_length(0)=1.
  - Otherwise cost=0.
  - mu_execution += cost. Go to DONE with rsp_valid pulse.
- DONE: req_ready=0 and done=1 until rst.
- Reserved op: one-cycle rsp_error pulse, no state change.
- mu_total = mu_discovery+mu_execution. It is registered in the same edge as either component changes, so the three are always consistent. All μ arithmetic wraps mod 2^MU_W; there is no saturation.
- rsp_module_id, rsp_reused and rsp_error hold until the next response.

## Timing
- Handshake at edge k. s = entries scanned: s=j+1 for a hit at entry j, s=num_modules for a miss, s=0 when the table is empty or dedup is disabled. COMMIT occurs at edge k+1+s, and rsp_valid is high for the cycle following it.
- req_ready rises in the same cycle as rsp_valid, so back-to-back requests are accepted on that edge.
- FINALIZE: rsp_valid and done follow edge k+1.
- rst asserted in any state, including mid-SEARCH or in DONE, wins at the next edge. The in-flight request is dropped with no response and no charge.

## Configuration
- PTABLE_DEDUP_EN defined: SEARCH is present and behaves as described above.
- PTABLE_DEDUP_EN undefined: SEARCH is compiled out. Every PNEW goes IDLE→COMMIT as a miss, and duplicate masks get new entries. rsp_reused is tied to 0. The μ charges are unchanged.

## Test plan
- Empty table, PNEW 0x1 → rsp_valid 2 cycles after the handshake, id 0, reused=0, mu_discovery=1, num_modules=1, cur_idx=0.
- PNEW 0x1, 0x2, 0x1 → third response id 0, reused=1, latency 3, num_modules=2, cur_idx=0, mu_discovery=3. With dedup compiled out: id 2, num_modules=3.
- PNEW 0x30 then FINALIZE → cost 3*2=6, mu_discovery=2, mu_execution=6, mu_total=8, done=1, req_ready=0.
- FINALIZE with no module → mu_execution=0, mu_total=0, done=1. A subsequent req_valid is not accepted.
- MAX_MODULES=4, five distinct single-bit masks → fifth response rsp_error=1, mu_discovery=5, num_modules=4, cur_idx=3.
- rst during SEARCH → all outputs 0 the next cycle. The following PNEW 0x4 returns id 0 with mu_discovery=1.
